icache_controller: RTL and testbench

//  Direct-mapped instruction cache and fill sequencer between the IF stage and instruction_memory.

---
 rtl/icache_pkg.sv | 28 ++
 rtl/icache_if.sv | 26 ++
 rtl/icache_line_array.sv | 48 ++++
 rtl/icache_controller.sv | 108 ++++++++++
 tb/tb_icache_controller.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared types, widths and address field helpers for the instruction cache.
// Index/tag helpers take the index width so the cache depth stays a module parameter.
package icache_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      UPDATE = 2'd2
   } state_t;

   localparam int BLOCK_W    = 128;
   localparam int OFFSET_W   = 4;
   localparam int MEM_ADDR_W = 28;
   localparam int DEF_SETS   = 8;

   function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int index_w);
      return addr >> (OFFSET_W + index_w);
   endfunction

   function automatic logic [31:0] addr_index(input logic [31:0] addr, input int index_w);
      return (addr >> OFFSET_W) & ((32'd1 << index_w) - 32'd1);
   endfunction

   function automatic logic [1:0] addr_word(input logic [31:0] addr);
      return 2'((addr >> 2) & 32'd3);
   endfunction

endpackage

// File: rtl/icache_if.sv
// CPU fetch port and instruction-memory block port of the instruction cache.
interface icache_if;
   import icache_pkg::*;

   logic                  READ;
   logic [31:0]           ADDRESS;
   logic [31:0]           INSTRUCTION;
   logic                  BUSYWAIT;
   logic                  FLUSH;
   logic                  MEM_READ;
   logic [MEM_ADDR_W-1:0] MEM_ADDRESS;
   logic [BLOCK_W-1:0]    MEM_READDATA;
   logic                  MEM_BUSYWAIT;

   // master: CPU plus instruction memory; slave: the cache itself
   modport master (
      output READ, ADDRESS, FLUSH, MEM_READDATA, MEM_BUSYWAIT,
      input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
   );

   modport slave (
      input  READ, ADDRESS, FLUSH, MEM_READDATA, MEM_BUSYWAIT,
      output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
   );

endinterface

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: asynchronous read, synchronous write and clear.
// Valid bits reset asynchronously; tag and data need no reset since valid gates them.
module icache_line_array
   import icache_pkg::*;
#(
   parameter int SETS    = DEF_SETS,
   parameter int INDEX_W = $clog2(SETS),
   parameter int TAG_W   = 32 - INDEX_W - OFFSET_W
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [INDEX_W-1:0] rd_index,
   output logic               rd_valid,
   output logic [TAG_W-1:0]   rd_tag,
   output logic [BLOCK_W-1:0] rd_data,
   input  logic               wr_en,
   input  logic [INDEX_W-1:0] wr_index,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [BLOCK_W-1:0] wr_data,
   input  logic               clear_all
);

   logic [SETS-1:0]               valid;
   logic [SETS-1:0][TAG_W-1:0]    tag_arr;
   logic [SETS-1:0][BLOCK_W-1:0]  data_arr;

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tag_arr[rd_index];
   assign rd_data  = data_arr[rd_index];

   // clear_all wins over a same-cycle write so a pending flush also drops the new line
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         valid <= '0;
      else if (clear_all)
         valid <= '0;
      else if (wr_en)
         valid[wr_index] <= 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (wr_en) begin
         tag_arr[wr_index]  <= wr_tag;
         data_arr[wr_index] <= wr_data;
      end
   end

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache: same-cycle hits, single-block fill on a miss.
// FSM IDLE -> FILL -> UPDATE -> IDLE; fence.i flushes are deferred until the fill finishes.
module icache_controller
   import icache_pkg::*;
#(
   parameter int SETS = DEF_SETS
) (
   input logic     CLK,
   input logic     RESET,
   icache_if.slave bus
);

   localparam int INDEX_W = $clog2(SETS);
   localparam int TAG_W   = 32 - INDEX_W - OFFSET_W;

   state_t                state, state_nx;
   logic [MEM_ADDR_W-1:0] miss_addr;
   logic [BLOCK_W-1:0]    fill_data;
   logic                  first_fill;
   logic                  flush_pend;

   logic [TAG_W-1:0]      tag;
   logic [INDEX_W-1:0]    index;
   logic [1:0]            word;
   logic                  line_valid;
   logic [TAG_W-1:0]      line_tag;
   logic [BLOCK_W-1:0]    line_data;
   logic                  hit, busy, mem_read, line_wr, clear_all;

   assign tag   = TAG_W'(addr_tag(bus.ADDRESS, INDEX_W));
   assign index = INDEX_W'(addr_index(bus.ADDRESS, INDEX_W));
   assign word  = addr_word(bus.ADDRESS);

   icache_line_array #(
      .SETS    (SETS),
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W)
   ) u_lines (
      .CLK       (CLK),
      .RESET     (RESET),
      .rd_index  (index),
      .rd_valid  (line_valid),
      .rd_tag    (line_tag),
      .rd_data   (line_data),
      .wr_en     (line_wr),
      .wr_index  (miss_addr[INDEX_W-1:0]),
      .wr_tag    (miss_addr[MEM_ADDR_W-1:INDEX_W]),
      .wr_data   (fill_data),
      .clear_all (clear_all)
   );

   assign hit = bus.READ & line_valid & (line_tag == tag);

   always_comb begin
      state_nx  = state;
      busy      = 1'b0;
      mem_read  = 1'b0;
      line_wr   = 1'b0;
      clear_all = 1'b0;
      case (state)
         IDLE: begin
            busy      = bus.READ & ~hit;
            clear_all = bus.FLUSH;
            if (bus.READ & ~hit)
               state_nx = FILL;
         end
         FILL: begin
            busy     = 1'b1;
            mem_read = 1'b1;
            // memory raises busy combinationally off MEM_READ, so its first-cycle level is stale
            if (!first_fill && !bus.MEM_BUSYWAIT)
               state_nx = UPDATE;
         end
         UPDATE: begin
            busy      = 1'b1;
            line_wr   = 1'b1;
            clear_all = flush_pend | bus.FLUSH;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state      <= IDLE;
         miss_addr  <= '0;
         fill_data  <= '0;
         first_fill <= 1'b0;
         flush_pend <= 1'b0;
      end else begin
         state      <= state_nx;
         first_fill <= (state == IDLE) && (state_nx == FILL);
         flush_pend <= (state == FILL) && (flush_pend || bus.FLUSH);
         if (state == IDLE && state_nx == FILL)
            miss_addr <= bus.ADDRESS[31:OFFSET_W];
         if (state == FILL && state_nx == UPDATE)
            fill_data <= bus.MEM_READDATA;
      end
   end

   // stall is masked during reset so a held READ does not stall against the cleared array
   assign bus.BUSYWAIT    = busy & RESET;
   assign bus.MEM_READ    = mem_read;
   assign bus.MEM_ADDRESS = miss_addr;
   assign bus.INSTRUCTION = hit ? line_data[{word, 5'b0} +: 32] : 32'h0;

endmodule

// File: tb/tb_icache_controller.sv
// Directed bench for icache_controller with a fixed-latency instruction memory model.
module tb_icache_controller;
   import icache_pkg::*;

   localparam int LAT = 3;
   localparam int MISS_STALL = 6;

   logic CLK;
   logic RESET;
   icache_if bus();

   icache_controller dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[15:0] + 16'hC0DE};
   endfunction

   function automatic logic [127:0] blk(input logic [27:0] ba);
      logic [31:0] base;
      base = {ba, 4'b0};
      return {word_at(base + 32'd12), word_at(base + 32'd8), word_at(base + 32'd4), word_at(base)};
   endfunction

   // memory: busy for LAT cycles from MEM_READ rising, then returns the block
   int            mcnt = 0;
   logic          mrq = 1'b0;
   int            n_req = 0;
   logic [27:0]   req_log[$];

   always @(posedge CLK) begin
      mrq  <= bus.MEM_READ;
      mcnt <= bus.MEM_READ ? mcnt + 1 : 0;
      if (bus.MEM_READ && !mrq) begin
         n_req <= n_req + 1;
         req_log.push_back(bus.MEM_ADDRESS);
      end
   end

   assign bus.MEM_BUSYWAIT = bus.MEM_READ && (mcnt < LAT);
   assign bus.MEM_READDATA = bus.MEM_BUSYWAIT ? {4{32'hDEADBEEF}} : blk(bus.MEM_ADDRESS);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic fetch(input string tag, input logic [31:0] a, input int exp_stall);
      int st;
      @(negedge CLK);
      bus.READ    = 1'b1;
      bus.ADDRESS = a;
      #1;
      st = 0;
      while (bus.BUSYWAIT !== 1'b0 && st < 40) begin
         @(negedge CLK);
         #1;
         st++;
      end
      check({tag, ".stall"}, 32'(st), 32'(exp_stall));
      check({tag, ".insn"}, bus.INSTRUCTION, word_at(a));
   endtask

   function automatic logic [31:0] last_req();
      if (req_log.size() == 0) return 32'hFFFF_FFFF;
      return 32'(req_log[req_log.size() - 1]);
   endfunction

   int n0, q0, st;

   initial begin
      RESET        = 1'b0;
      bus.READ     = 1'b1;
      bus.ADDRESS  = 32'h4;
      bus.FLUSH    = 1'b0;
      #1;
      check("rst.busy", 32'(bus.BUSYWAIT), 32'd0);
      check("rst.mrd", 32'(bus.MEM_READ), 32'd0);
      check("rst.maddr", 32'(bus.MEM_ADDRESS), 32'd0);
      check("rst.insn", bus.INSTRUCTION, 32'd0);
      bus.READ = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b1;

      // 1 cold miss
      n0 = n_req;
      fetch("t1", 32'h4, MISS_STALL);
      check("t1.nreq", 32'(n_req - n0), 32'd1);
      check("t1.maddr", last_req(), 32'h0);

      // 2 spatial hit in the same block
      n0 = n_req;
      fetch("t2", 32'hC, 0);
      check("t2.mrd", 32'(bus.MEM_READ), 32'd0);
      check("t2.nreq", 32'(n_req - n0), 32'd0);

      // 3 conflict on index 0 evicts block 0
      fetch("t3.conf", 32'h84, MISS_STALL);
      check("t3.maddr", last_req(), 32'h8);
      fetch("t3.evict", 32'h4, MISS_STALL);
      check("t3.maddr2", last_req(), 32'h0);

      // 4 flush during a fill
      n0 = n_req;
      @(negedge CLK);
      bus.READ    = 1'b1;
      bus.ADDRESS = 32'h10;
      #1;
      check("t4.miss", 32'(bus.BUSYWAIT), 32'd1);
      @(negedge CLK);
      #1;
      check("t4.mrd", 32'(bus.MEM_READ), 32'd1);
      check("t4.maddr", 32'(bus.MEM_ADDRESS), 32'h1);
      bus.FLUSH = 1'b1;
      @(negedge CLK);
      bus.FLUSH = 1'b0;
      #1;
      st = 0;
      while (bus.MEM_READ !== 1'b0 && st < 40) begin
         @(negedge CLK);
         #1;
         st++;
      end
      check("t4.upd_mrd", 32'(bus.MEM_READ), 32'd0);
      check("t4.upd_busy", 32'(bus.BUSYWAIT), 32'd1);
      @(negedge CLK);
      bus.READ = 1'b0;
      #1;
      check("t4.drop", 32'(bus.BUSYWAIT), 32'd0);
      check("t4.nreq1", 32'(n_req - n0), 32'd1);
      fetch("t4.refetch", 32'h10, MISS_STALL);
      check("t4.nreq2", 32'(n_req - n0), 32'd2);
      fetch("t4.blk0", 32'hC, MISS_STALL);

      // 5 reset in the middle of a fill
      @(negedge CLK);
      bus.READ    = 1'b1;
      bus.ADDRESS = 32'h20;
      @(negedge CLK);
      #1;
      check("t5.mrd", 32'(bus.MEM_READ), 32'd1);
      check("t5.mbusy", 32'(bus.MEM_BUSYWAIT), 32'd1);
      RESET = 1'b0;
      #1;
      check("t5.rst_mrd", 32'(bus.MEM_READ), 32'd0);
      check("t5.rst_busy", 32'(bus.BUSYWAIT), 32'd0);
      @(negedge CLK);
      #1;
      check("t5.hold_mrd", 32'(bus.MEM_READ), 32'd0);
      check("t5.hold_busy", 32'(bus.BUSYWAIT), 32'd0);
      bus.READ = 1'b0;
      RESET    = 1'b1;
      n0 = n_req;
      fetch("t5.refill", 32'h4, MISS_STALL);
      check("t5.nreq", 32'(n_req - n0), 32'd1);
      check("t5.maddr", last_req(), 32'h0);

      // 6 flush while idle, then a sequential run through four blocks
      @(negedge CLK);
      bus.READ  = 1'b0;
      bus.FLUSH = 1'b1;
      @(negedge CLK);
      bus.FLUSH = 1'b0;
      n0 = n_req;
      q0 = req_log.size();
      for (int i = 0; i < 16; i++)
         fetch($sformatf("t6.%0d", i), 32'(i * 4), (i % 4 == 0) ? MISS_STALL : 0);
      check("t6.nreq", 32'(n_req - n0), 32'd4);
      for (int i = 0; i < 4; i++)
         check($sformatf("t6.maddr%0d", i),
               (q0 + i < req_log.size()) ? 32'(req_log[q0 + i]) : 32'hFFFF_FFFF, 32'(i));

      @(negedge CLK);
      bus.READ = 1'b0;
      #1;
      check("end.idle", 32'(bus.BUSYWAIT), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
